// File: rtl/ddr_pkg.sv
// ddr_pkg: definitions shared by the DDR reader and the DDR writer.
//   - Field offsets and widths of the 64-bit cfg_data word
//     ({c, h, w, base_addr} from the MSB down to the LSB).
//   - bpp(): number of bytes per pixel for a given pixel width.
//   - state_t: the run-control FSM states.
package ddr_pkg;

    localparam int CFG_W    = 64;
    localparam int BASE_LSB = 0;
    localparam int BASE_W   = 32;
    localparam int W_LSB    = 32;
    localparam int W_W      = 10;
    localparam int H_LSB    = 42;
    localparam int H_W      = 10;
    localparam int C_LSB    = 52;
    localparam int C_W      = 12;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE,
        FLUSH
    } state_t;

    function automatic int bpp(input int b_pixel);
        return b_pixel / 8;
    endfunction

endpackage

// File: rtl/ddr_rd_fifo.sv
// ddr_rd_fifo: small synchronous first-word-fall-through FIFO for returned
// read data.
//   clk, rstn   clock, synchronous active-low reset
//   clr         drop all contents (pointers and count back to zero)
//   push/push_data  write one word (ignored when full)
//   pop/pop_data    pop_data always shows the head; pop advances it
//                   (ignored when empty)
//   count, empty, full  occupancy status
// The head must be visible in the same cycle it becomes valid, so the
// storage array is read asynchronously (distributed RAM at this depth).
module ddr_rd_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          clr,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         pop_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          empty,
    output logic                          full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            // Depth is a power of two, so the pointers wrap on their own.
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ddr_reader.sv
// ddr_reader: loads a channel-blocked tensor from DDR and streams it to the
// compute array, one N_KERNEL-pixel word per beat.
//   clk, rstn             clock, synchronous active-low reset
//   cfg_data              {c[63:52], h[51:42], w[41:32], base_addr[31:0]}
//   cfg_run               high = run/hold, low = abort/return to idle
//   cfg_done              all beats of the run delivered (held until cfg_run=0)
//   m_axis_*              read-address stream (one beat per byte address)
//   s_axis_*              returned read data, in address order
//   ddr_data/valid/ready  beats to the compute datapath
// Address order: outer loop over channel groups, inner loop over pixels.
// Addresses are only issued while the return buffer has room for the data of
// every address already in flight, so returned data is never back-pressured.
module ddr_reader
    import ddr_pkg::*;
#(
    parameter int N_KERNEL   = 4,
    parameter int B_PIXEL    = 16,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [CFG_W-1:0]      cfg_data,
    input  logic                  cfg_run,
    output logic                  cfg_done,
    output logic [ADDR_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] ddr_data,
    output logic                  ddr_valid,
    input  logic                  ddr_ready
);

    localparam int BPP        = bpp(B_PIXEL);
    localparam int GROUP_STEP = N_KERNEL * BPP;
    localparam int DC_W       = C_W + $clog2(BPP);
    localparam int XY_W       = 20;
    localparam int OUT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W      = OUT_W + 1;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] base_reg;
    logic [DC_W-1:0]       pixel_step_reg;
    logic [DC_W-1:0]       last_dc_reg;
    logic [XY_W-1:0]       last_xy_reg;
    logic [XY_W-1:0]       cnt_xy_reg;
    logic [DC_W-1:0]       dc_reg;
    logic [ADDR_WIDTH-1:0] dxy_reg;
    logic [OUT_W-1:0]      outstanding_reg;
    logic                  m_tvalid_reg;
    logic [ADDR_WIDTH-1:0] m_tdata_reg;
    logic                  done_reg;

    logic [W_W-1:0]        cfg_w;
    logic [H_W-1:0]        cfg_h;
    logic [C_W-1:0]        cfg_c;
    logic                  running;
    logic                  abort;
    logic                  m_hs;
    logic                  s_hs;
    logic                  pop;
    logic                  is_last_xy;
    logic                  is_last_grp;
    logic [ADDR_WIDTH-1:0] dxy_next;
    logic [DC_W-1:0]       dc_next;
    logic [ADDR_WIDTH-1:0] addr_cur;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [SUM_W-1:0]      in_use;
    logic                  credit_ok;
    logic                  drain_done;

    logic                  fifo_push;
    logic [OUT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;

    assign cfg_w = cfg_data[W_LSB +: W_W];
    assign cfg_h = cfg_data[H_LSB +: H_W];
    assign cfg_c = cfg_data[C_LSB +: C_W];

    assign running       = (state_reg == ISSUE) || (state_reg == DRAIN);
    assign abort         = running && !cfg_run;
    assign s_axis_tready = running || (state_reg == FLUSH);
    assign m_hs          = m_tvalid_reg & m_axis_tready;
    assign s_hs          = s_axis_tvalid & s_axis_tready;
    assign ddr_valid     = ~fifo_empty;
    assign pop           = ddr_valid & ddr_ready;
    // Beats arriving during FLUSH belong to an aborted run and are dropped.
    assign fifo_push     = s_hs && running && !fifo_full;

    assign is_last_xy  = (cnt_xy_reg == last_xy_reg);
    assign is_last_grp = (dc_reg == last_dc_reg);
    assign dxy_next    = is_last_xy ? '0 : dxy_reg + ADDR_WIDTH'(pixel_step_reg);
    assign dc_next     = is_last_xy ? dc_reg + DC_W'(GROUP_STEP) : dc_reg;
    assign addr_cur    = base_reg + dxy_reg + ADDR_WIDTH'(dc_reg);
    assign addr_next   = base_reg + dxy_next + ADDR_WIDTH'(dc_next);

    // Slots committed = in flight + buffered (+ the address accepted now).
    // Pops this cycle are ignored, which only makes the check conservative.
    assign in_use    = SUM_W'(outstanding_reg) + SUM_W'(fifo_count) + SUM_W'(m_hs);
    assign credit_ok = (in_use < SUM_W'(FIFO_DEPTH));

    // Finished when nothing is in flight and the last buffered beat is
    // either gone or leaving on this very cycle.
    assign drain_done = (outstanding_reg == '0) &&
                        (fifo_empty || ((fifo_count == OUT_W'(1)) && pop));

    assign cfg_done      = done_reg;
    assign m_axis_tvalid = m_tvalid_reg;
    assign m_axis_tdata  = m_tdata_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            base_reg        <= '0;
            pixel_step_reg  <= '0;
            last_dc_reg     <= '0;
            last_xy_reg     <= '0;
            cnt_xy_reg      <= '0;
            dc_reg          <= '0;
            dxy_reg         <= '0;
            outstanding_reg <= '0;
            m_tvalid_reg    <= 1'b0;
            m_tdata_reg     <= '0;
            done_reg        <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    done_reg     <= 1'b0;
                    m_tvalid_reg <= 1'b0;
                    if (cfg_run) begin
                        base_reg       <= ADDR_WIDTH'(cfg_data[BASE_LSB +: BASE_W]);
                        last_xy_reg    <= XY_W'(cfg_w) * XY_W'(cfg_h) - XY_W'(1);
                        pixel_step_reg <= DC_W'(cfg_c) * DC_W'(BPP);
                        last_dc_reg    <= DC_W'(cfg_c) * DC_W'(BPP) - DC_W'(GROUP_STEP);
                        cnt_xy_reg     <= '0;
                        dc_reg         <= '0;
                        dxy_reg        <= '0;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Counters always describe the address currently on the
                    // bus, or the next one to present when tvalid is low.
                    if (!cfg_run) begin
                        m_tvalid_reg <= 1'b0;
                        state_reg    <= FLUSH;
                    end else if (m_hs) begin
                        if (is_last_xy && is_last_grp) begin
                            m_tvalid_reg <= 1'b0;
                            state_reg    <= DRAIN;
                        end else begin
                            cnt_xy_reg   <= is_last_xy ? '0 : cnt_xy_reg + XY_W'(1);
                            dxy_reg      <= dxy_next;
                            dc_reg       <= dc_next;
                            m_tdata_reg  <= addr_next;
                            m_tvalid_reg <= credit_ok;
                        end
                    end else if (!m_tvalid_reg && credit_ok) begin
                        m_tdata_reg  <= addr_cur;
                        m_tvalid_reg <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!cfg_run) begin
                        state_reg <= FLUSH;
                    end else if (drain_done) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (!cfg_run) begin
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                FLUSH: begin
                    if (outstanding_reg == '0) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // An address accepted in the abort cycle still has data coming.
            unique case ({m_hs, s_hs})
                2'b10:   outstanding_reg <= outstanding_reg + OUT_W'(1);
                2'b01:   outstanding_reg <= outstanding_reg - OUT_W'(1);
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    ddr_rd_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (abort),
        .push      (fifo_push),
        .push_data (s_axis_tdata),
        .pop       (pop),
        .pop_data  (ddr_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
